// File: rtl/accum_seq_8bits_pkg.sv
// Shared types and constants for the 8-bit sequential accumulator:
// FSM state encoding, saturation limits and the operand-count port width.
package accum_seq_8bits_pkg;

    localparam int WIDTH   = 8;
    localparam int N_OPS_W = 5;

    localparam logic [WIDTH-1:0] SAT_POS = 8'h7F;
    localparam logic [WIDTH-1:0] SAT_NEG = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // An overflow always moves away from the sign of the accumulator it started from.
    function automatic logic [WIDTH-1:0] sat_limit(input logic acc_neg);
        return acc_neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/accum_seq_8bits_if.sv
// Burst setup, operand stream and result stream of the accumulator.
// The master drives the requests; the slave is the accumulator.
interface accum_seq_8bits_if;
    import accum_seq_8bits_pkg::*;

    logic               start;
    logic [N_OPS_W-1:0] n_ops;
    logic [WIDTH-1:0]   init;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_sub;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_acc;
    logic               out_ov;
    logic               busy;

    modport master (
        output start, n_ops, init, in_valid, in_data, in_sub, out_ready,
        input  in_ready, out_valid, out_acc, out_ov, busy
    );

    modport slave (
        input  start, n_ops, init, in_valid, in_data, in_sub, out_ready,
        output in_ready, out_valid, out_acc, out_ov, busy
    );

endinterface

// File: rtl/accum_seq_8bits_addsub.sv
// Combinational 8-bit signed add/subtract stage: w = a + b (m=0) or a - b (m=1),
// with ov_flag raised on signed overflow.
module accum_seq_8bits_addsub
    import accum_seq_8bits_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic [WIDTH-1:0] w,
    output logic             ov_flag
);

    logic [WIDTH-1:0] b_eff;

    // Subtraction is a + ~b + 1, so overflow reduces to the addition rule on b_eff.
    assign b_eff   = m ? ~b : b;
    assign w       = a + b_eff + WIDTH'(m);
    assign ov_flag = (a[WIDTH-1] == b_eff[WIDTH-1]) && (w[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/accum_seq_8bits.sv
// Sequential signed accumulator: loads init, folds a burst of operands through
// the add/sub stage, then holds the final sum and sticky overflow until taken.
//
// state    | meaning
// ST_IDLE  | waiting for start; acc keeps the last result
// ST_ACCUM | in_ready high, one operand accepted per handshake
// ST_DONE  | out_valid high, result held until out_ready
module accum_seq_8bits
    import accum_seq_8bits_pkg::*;
#(
    parameter int MAX_OPS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    accum_seq_8bits_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_OPS + 1);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   n_ops_clamped;
    logic               ov;
    logic               ov_flag;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               hs;

    accum_seq_8bits_addsub u_addsub (
        .a       (acc),
        .b       (bus.in_data),
        .m       (bus.in_sub),
        .w       (sum),
        .ov_flag (ov_flag)
    );

    always_comb begin
        if (int'(bus.n_ops) > MAX_OPS) n_ops_clamped = CNT_W'(MAX_OPS);
        else                           n_ops_clamped = CNT_W'(bus.n_ops);
    end

    assign acc_next = (SATURATE && ov_flag) ? sat_limit(acc[WIDTH-1]) : sum;
    assign hs       = bus.in_valid && in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            ov          <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc    <= bus.init;
                        ov     <= 1'b0;
                        busy_q <= 1'b1;
                        if (n_ops_clamped != '0) begin
                            cnt        <= n_ops_clamped;
                            in_ready_q <= 1'b1;
                            state      <= ST_ACCUM;
                        end else begin
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (hs) begin
                        acc <= acc_next;
                        ov  <= ov | ov_flag;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc;
    assign bus.out_ov    = ov;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_accum_seq_8bits.sv
// Drives a wrapping and a saturating accumulator with identical stimulus and
// scores both against a reference model through an expected-result queue.
module tb_accum_seq_8bits;
    import accum_seq_8bits_pkg::*;

    logic clk;
    logic rst;
    logic       start;
    logic [4:0] n_ops;
    logic [7:0] init_v;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sub;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] acc_w;
        logic       ov_w;
        logic [7:0] acc_s;
        logic       ov_s;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] m_acc_w, m_acc_s;
    logic       m_ov_w, m_ov_s;
    int         m_left;

    accum_seq_8bits_if if_w ();
    accum_seq_8bits_if if_s ();

    assign if_w.start = start;     assign if_s.start = start;
    assign if_w.n_ops = n_ops;     assign if_s.n_ops = n_ops;
    assign if_w.init = init_v;     assign if_s.init = init_v;
    assign if_w.in_valid = in_valid; assign if_s.in_valid = in_valid;
    assign if_w.in_data = in_data; assign if_s.in_data = in_data;
    assign if_w.in_sub = in_sub;   assign if_s.in_sub = in_sub;
    assign if_w.out_ready = out_ready; assign if_s.out_ready = out_ready;

    accum_seq_8bits #(.MAX_OPS(16), .SATURATE(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(if_w.slave));
    accum_seq_8bits #(.MAX_OPS(16), .SATURATE(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(if_s.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model_step(input logic [7:0] a, input logic [7:0] d,
                                              input logic sub, input bit sat);
        int sa, sd, r;
        logic ovf;
        logic [7:0] res;
        sa  = int'($signed(a));
        sd  = int'($signed(d));
        r   = sub ? sa - sd : sa + sd;
        ovf = (r > 127) || (r < -128);
        res = r[7:0];
        if (sat && ovf) res = (r > 127) ? 8'h7F : 8'h80;
        return {ovf, res};
    endfunction

    task automatic push_exp();
        exp_t e;
        e.acc_w = m_acc_w; e.ov_w = m_ov_w;
        e.acc_s = m_acc_s; e.ov_s = m_ov_s;
        exp_q.push_back(e);
    endtask

    task automatic start_burst(input logic [7:0] iv, input logic [4:0] n);
        start = 1'b1; n_ops = n; init_v = iv;
        @(posedge clk); #1;
        start = 1'b0;
        m_acc_w = iv; m_acc_s = iv; m_ov_w = 1'b0; m_ov_s = 1'b0;
        m_left = (n > 5'd16) ? 16 : int'(n);
        if (m_left == 0) push_exp();
        chk("start_busy", {31'b0, if_w.busy}, 1);
        chk("start_in_ready", {31'b0, if_s.in_ready}, (m_left != 0) ? 1 : 0);
    endtask

    task automatic send_op(input logic [7:0] d, input logic sub, input int gap);
        logic [8:0] r;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("gap_hold_w", {24'b0, if_w.out_acc}, {24'b0, m_acc_w});
            chk("gap_hold_s", {24'b0, if_s.out_acc}, {24'b0, m_acc_s});
        end
        chk("in_ready", {31'b0, if_w.in_ready}, 1);
        chk("pre_valid", {31'b0, if_w.out_valid}, 0);
        in_valid = 1'b1; in_data = d; in_sub = sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        r = model_step(m_acc_w, d, sub, 1'b0);
        m_acc_w = r[7:0]; m_ov_w = m_ov_w | r[8];
        r = model_step(m_acc_s, d, sub, 1'b1);
        m_acc_s = r[7:0]; m_ov_s = m_ov_s | r[8];
        chk("live_w", {24'b0, if_w.out_acc}, {24'b0, m_acc_w});
        chk("live_s", {24'b0, if_s.out_acc}, {24'b0, m_acc_s});
        m_left--;
        if (m_left == 0) begin
            push_exp();
            chk("post_valid", {31'b0, if_w.out_valid}, 1);
        end
    endtask

    task automatic collect(input int hold, input logic start_on_exit);
        exp_t e;
        int t = 0;
        while (!if_w.out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("out_valid_wait", {31'b0, if_w.out_valid}, 1);
        if (exp_q.size() == 0) begin
            chk("exp_queue_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, if_w.out_valid}, 1);
            chk("hold_acc", {24'b0, if_w.out_acc}, {24'b0, e.acc_w});
            chk("hold_ov", {31'b0, if_w.out_ov}, {31'b0, e.ov_w});
        end
        chk("acc_w", {24'b0, if_w.out_acc}, {24'b0, e.acc_w});
        chk("ov_w", {31'b0, if_w.out_ov}, {31'b0, e.ov_w});
        chk("acc_s", {24'b0, if_s.out_acc}, {24'b0, e.acc_s});
        chk("ov_s", {31'b0, if_s.out_ov}, {31'b0, e.ov_s});
        chk("valid_s", {31'b0, if_s.out_valid}, 1);
        out_ready = 1'b1; start = start_on_exit; n_ops = 5'd1;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        chk("exit_valid", {31'b0, if_w.out_valid}, 0);
        chk("exit_busy", {31'b0, if_w.busy}, 0);
        chk("exit_busy_s", {31'b0, if_s.busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] last_w;
        rst = 1'b1; start = 1'b0; n_ops = '0; init_v = '0;
        in_valid = 1'b0; in_data = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, if_w.in_ready}, 0);
        chk("rst_out_valid", {31'b0, if_w.out_valid}, 0);
        chk("rst_out_acc", {24'b0, if_w.out_acc}, 0);
        chk("rst_busy", {31'b0, if_s.busy}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // reset mid-burst after an overflowing operand
        start_burst(8'h7F, 5'd3);
        send_op(8'h01, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'b0, if_w.in_ready}, 0);
        chk("mid_rst_out_valid", {31'b0, if_w.out_valid}, 0);
        chk("mid_rst_acc_w", {24'b0, if_w.out_acc}, 0);
        chk("mid_rst_acc_s", {24'b0, if_s.out_acc}, 0);
        chk("mid_rst_ov", {31'b0, if_w.out_ov}, 0);
        chk("mid_rst_busy", {31'b0, if_w.busy}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {30'b0, if_w.busy, if_w.in_ready}, 0);

        // 5 + 3 + 4 - (-2) = 0x0E
        start_burst(8'h05, 5'd3);
        send_op(8'h03, 1'b0, 0);
        send_op(8'h04, 1'b0, 0);
        send_op(8'hFE, 1'b1, 0);
        collect(0, 1'b0);

        // positive overflow
        start_burst(8'h7F, 5'd1);
        send_op(8'h01, 1'b0, 0);
        collect(0, 1'b0);

        // negative overflow via subtraction
        start_burst(8'h80, 5'd1);
        send_op(8'h01, 1'b1, 0);
        collect(0, 1'b0);

        // empty burst with back-pressure
        start_burst(8'h2A, 5'd0);
        collect(5, 1'b0);
        last_w = 8'h2A;

        // operand offered in IDLE is ignored
        in_valid = 1'b1; in_data = 8'h33; in_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("idle_in_ready", {31'b0, if_w.in_ready}, 0);
        chk("idle_acc_hold", {24'b0, if_w.out_acc}, {24'b0, last_w});

        // gaps and a stray start mid-burst
        start_burst(8'h10, 5'd3);
        send_op(8'h20, 1'b0, 2);
        start = 1'b1; n_ops = 5'd2; init_v = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        chk("stray_start_acc", {24'b0, if_w.out_acc}, {24'b0, m_acc_w});
        chk("stray_start_ready", {31'b0, if_w.in_ready}, 1);
        send_op(8'h70, 1'b0, 1);
        send_op(8'h05, 1'b1, 3);
        collect(2, 1'b1);
        start_burst(8'hF0, 5'd2);
        send_op(8'h90, 1'b0, 0);
        send_op(8'h7F, 1'b1, 0);
        collect(0, 1'b0);

        // n_ops beyond the maximum clamps to 16 operands
        start_burst(8'h00, 5'd31);
        for (int i = 0; i < 16; i++)
            send_op(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        collect(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
